// File: rtl/image_loader.sv
// rtl/image_loader.sv - sync-header hunting byte-stream loader for the image RAM
//
// Purpose: hunts for the SYNC0/SYNC1 header in the received byte stream,
// writes the following N_PIXELS bytes into the image RAM at addresses
// 0..N_PIXELS-1, then holds img_valid_o until the consumer acknowledges.
// An inter-byte idle timeout aborts stalled frames.
//
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN
//   defined   - a trailing checksum byte (sum of pixels mod 256) is checked
//   undefined - the frame ends after the final pixel, err_cksum_o is 0
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   rx_data_i      received byte, qualified by rx_valid_i
//   rx_valid_i     one-cycle strobe per received byte
//   img_ack_i      consumer releases the frame (honoured in HOLD only)
//   ram_wr_addr_o  RAM write address
//   ram_wr_data_o  RAM write data
//   ram_wr_en_o    RAM write enable, one cycle per pixel
//   img_valid_o    complete frame present in RAM
//   busy_o         frame reception in progress (LOAD/CHECK)
//   pixel_count_o  pixels written in the current frame
//   err_timeout_o  sticky timeout-abort flag, cleared by the next header
//   err_cksum_o    sticky checksum-mismatch flag, cleared by the next header

module image_loader #(
  parameter int unsigned N_PIXELS       = 784,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       img_ack_i,
  output logic [9:0] ram_wr_addr_o,
  output logic [7:0] ram_wr_data_o,
  output logic       ram_wr_en_o,
  output logic       img_valid_o,
  output logic       busy_o,
  output logic [9:0] pixel_count_o,
  output logic       err_timeout_o,
  output logic       err_cksum_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0]  LAST_PIX = 10'(N_PIXELS - 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

`ifdef IMAGE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HUNT0, S_HUNT1, S_LOAD, S_CHECK, S_HOLD} state_e;
`else
  typedef enum logic [2:0] {S_HUNT0, S_HUNT1, S_LOAD, S_HOLD} state_e;
`endif

  state_e        state_q, state_d;
  logic [9:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [9:0]    count_q, count_d;
  logic          err_to_q, err_to_d;
  logic [TW-1:0] idle_q, idle_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d;
  logic          err_ck_q, err_ck_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    valid_d  = valid_q;
    count_d  = count_q;
    err_to_d = err_to_q;
    idle_d   = idle_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    acc_d    = acc_q;
    err_ck_d = err_ck_q;
`endif
    unique case (state_q)
      S_HUNT0: begin
        if (rx_valid_i && rx_data_i == SYNC0) state_d = S_HUNT1;
      end
      S_HUNT1: begin
        if (rx_valid_i) begin
          if (rx_data_i == SYNC1) begin
            state_d  = S_LOAD;
            count_d  = '0;
            idle_d   = '0;
            err_to_d = 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            acc_d    = '0;
            err_ck_d = 1'b0;
`endif
          end else if (rx_data_i != SYNC0) begin
            // A repeated SYNC0 may still be the real first header byte.
            state_d = S_HUNT0;
          end
        end
      end
      S_LOAD: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid_i) begin
          idle_d  = '0;
          addr_d  = count_q;
          data_d  = rx_data_i;
          wr_en_d = 1'b1;
          count_d = count_q + 10'd1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
          acc_d   = acc_q + rx_data_i;
          if (count_q == LAST_PIX) state_d = S_CHECK;
`else
          if (count_q == LAST_PIX) state_d = S_HOLD;
`endif
        end else if (idle_q == IDLE_LIMIT) begin
          err_to_d = 1'b1;
          state_d  = S_HUNT0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`ifdef IMAGE_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid_i) begin
          idle_d = '0;
          if (rx_data_i == acc_q) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
          end else begin
            err_ck_d = 1'b1;
            state_d  = S_HUNT0;
          end
        end else if (idle_q == IDLE_LIMIT) begin
          err_to_d = 1'b1;
          state_d  = S_HUNT0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`endif
      S_HOLD: begin
        // Without a checksum, valid rises one edge after entering HOLD so the
        // final pixel has already committed. Ack only counts once valid is up.
        if (img_ack_i && valid_q) begin
          state_d = S_HUNT0;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = S_HUNT0;
    endcase
`ifdef IMAGE_LOADER_CHECKSUM_EN
    busy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
    busy_d = (state_d == S_LOAD);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_HUNT0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      err_to_q <= 1'b0;
      idle_q   <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      acc_q    <= '0;
      err_ck_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      err_to_q <= err_to_d;
      idle_q   <= idle_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      acc_q    <= acc_d;
      err_ck_q <= err_ck_d;
`endif
    end
  end

  assign ram_wr_addr_o = addr_q;
  assign ram_wr_data_o = data_q;
  assign ram_wr_en_o   = wr_en_q;
  assign img_valid_o   = valid_q;
  assign busy_o        = busy_q;
  assign pixel_count_o = count_q;
  assign err_timeout_o = err_to_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  assign err_cksum_o   = err_ck_q;
`else
  assign err_cksum_o   = 1'b0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - directed, table-driven bench for image_loader

module tb_image_loader;

  localparam int unsigned NP = 784;
  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       img_ack;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       img_valid;
  logic       busy;
  logic [9:0] pix_cnt;
  logic       err_to;
  logic       err_ck;

  image_loader #(
    .N_PIXELS(NP),
    .TIMEOUT_CYCLES(TO),
    .SYNC0(8'hAA),
    .SYNC1(8'h55)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .img_ack_i(img_ack),
    .ram_wr_addr_o(wr_addr),
    .ram_wr_data_o(wr_data),
    .ram_wr_en_o(wr_en),
    .img_valid_o(img_valid),
    .busy_o(busy),
    .pixel_count_o(pix_cnt),
    .err_timeout_o(err_to),
    .err_cksum_o(err_ck)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  int bad_addr = 0;

  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      wr_count <= wr_count + 1;
      if (wr_addr >= 10'(NP)) bad_addr <= bad_addr + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ack);
    rx_valid = v;
    rx_data  = d;
    img_ack  = ack;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    img_ack  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_addr"}, 32'(wr_addr), 0);
    check({tag, "_data"}, 32'(wr_data), 0);
    check({tag, "_valid"}, 32'(img_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_count"}, 32'(pix_cnt), 0);
    check({tag, "_err_to"}, 32'(err_to), 0);
    check({tag, "_err_ck"}, 32'(err_ck), 0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ack;
    logic       e_busy;
    logic       e_en;
    logic [9:0] e_addr;
    logic [7:0] e_data;
    logic [9:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int perr;
    int w0;
    logic [7:0] ck;

    tbl[0] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[1] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[2] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[3] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[4] = '{1'b1, 8'h37, 1'b0, 1'b1, 1'b1, 10'd0, 8'h37, 10'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'd0, 8'h37, 10'd1};
    tbl[6] = '{1'b1, 8'h38, 1'b0, 1'b1, 1'b1, 10'd1, 8'h38, 10'd2};
    tbl[7] = '{1'b1, 8'h39, 1'b0, 1'b1, 1'b1, 10'd2, 8'h39, 10'd3};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'd2, 8'h39, 10'd3};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 10'd2, 8'h39, 10'd3};

    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    img_ack = 1'b0;
    #23;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Header hunt with garbage, first pixels, ack ignored outside HOLD.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].ack);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("vec%0d_en", i), 32'(wr_en), 32'(tbl[i].e_en));
      check($sformatf("vec%0d_addr", i), 32'(wr_addr), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d_data", i), 32'(wr_data), 32'(tbl[i].e_data));
      check($sformatf("vec%0d_cnt", i), 32'(pix_cnt), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_valid", i), 32'(img_valid), 0);
    end

    // Byte arriving exactly at timeout expiry wins.
    for (int i = 3; i < 99; i++) step(1'b1, 8'(i), 1'b0);
    idle(TO - 1);
    step(1'b1, 8'h63, 1'b0);
    check("simul_busy", 32'(busy), 1);
    check("simul_err_to", 32'(err_to), 0);
    check("simul_cnt", 32'(pix_cnt), 100);

    // Stall after 100 pixels.
    idle(TO - 1);
    check("pre_to_busy", 32'(busy), 1);
    check("pre_to_err", 32'(err_to), 0);
    idle(1);
    check("to_err", 32'(err_to), 1);
    check("to_busy", 32'(busy), 0);
    check("to_valid", 32'(img_valid), 0);
    check("to_wr_en", 32'(wr_en), 0);

    // New header clears the sticky timeout flag.
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    check("hdr_err_to", 32'(err_to), 0);
    check("hdr_busy", 32'(busy), 1);
    check("hdr_cnt", 32'(pix_cnt), 0);

    // Full frame, one pixel every 3rd cycle.
    w0 = wr_count;
    perr = 0;
    ck = 8'h00;
    for (int i = 0; i < int'(NP); i++) begin
      step(1'b1, 8'(i), 1'b0);
      ck = ck + 8'(i);
      if (!(wr_en === 1'b1 && wr_addr === 10'(i) && wr_data === 8'(i))) begin
        if (perr == 0) $display("first bad pixel %0d: en=%b addr=%0d data=%0h", i, wr_en, wr_addr, wr_data);
        perr++;
      end
      if (i != int'(NP) - 1) idle(2);
    end
    check("stream_writes", 32'(perr), 0);
    check("last_cnt", 32'(pix_cnt), NP);
    check("last_valid_early", 32'(img_valid), 0);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    check("last_busy_check", 32'(busy), 1);
    step(1'b1, ck, 1'b0);
    check("ck_ok_valid", 32'(img_valid), 1);
    check("ck_ok_err", 32'(err_ck), 0);
`else
    check("last_busy", 32'(busy), 0);
    step(1'b0, 8'h00, 1'b0);
    check("commit_valid", 32'(img_valid), 1);
    check("commit_wr_en", 32'(wr_en), 0);
`endif
    check("frame_wr_count", 32'(wr_count - w0), NP);

    // HOLD drops all bytes, then ack releases.
    w0 = wr_count;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) step(1'b1, 8'hAA, 1'b0);
      else if (k == 4) step(1'b1, 8'h55, 1'b0);
      else step(1'b1, 8'(k + 200), 1'b0);
    end
    check("hold_writes", 32'(wr_count - w0), 0);
    check("hold_valid", 32'(img_valid), 1);
    check("hold_cnt", 32'(pix_cnt), NP);
    check("hold_busy", 32'(busy), 0);
    step(1'b0, 8'h00, 1'b1);
    check("ack_valid", 32'(img_valid), 0);
    step(1'b1, 8'h55, 1'b0);
    check("ack_hunt0", 32'(busy), 0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    check("rehdr_busy", 32'(busy), 1);

    // Reset during the write cycle of pixel 400.
    for (int i = 0; i <= 400; i++) step(1'b1, 8'(i), 1'b0);
    check("p400_en", 32'(wr_en), 1);
    check("p400_addr", 32'(wr_addr), 400);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check_all_zero("postrst");
    step(1'b1, 8'h55, 1'b0);
    check("postrst_hunt0", 32'(busy), 0);

`ifdef IMAGE_LOADER_CHECKSUM_EN
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < int'(NP); i++) step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    check("ones_ok_valid", 32'(img_valid), 1);
    check("ones_ok_err", 32'(err_ck), 0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < int'(NP); i++) step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    check("ones_bad_err", 32'(err_ck), 1);
    check("ones_bad_valid", 32'(img_valid), 0);
    check("ones_bad_busy", 32'(busy), 0);
`else
    check("no_ck_err", 32'(err_ck), 0);
`endif
    check("addr_range", 32'(bad_addr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_loader.md
# image_loader

Byte-stream receiver that sits directly upstream of the 784-byte image RAM. Hunts for a two-byte sync header in the UART RX byte stream, writes the following `N_PIXELS` pixel bytes into the RAM through its write port, then raises `img_valid` for the inference engine. It guards against stalled transfers with an inter-byte timeout. Optionally, it also verifies a trailing checksum.

## Interface
- `N_PIXELS`, 784, pixel bytes per frame; also the final RAM address + 1.
- `TIMEOUT_CYCLES`, 1000000, idle clocks allowed between bytes while in LOAD/CHECK before the frame is aborted.
- `SYNC0`, 8'hAA, first header byte.
- `SYNC1`, 8'h55, second header byte.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle strobe per received byte; no back-pressure.
- `img_ack`  in  1  consumer releases the frame; honoured only in HOLD.
- `ram_wr_addr`  out  10  RAM write address.
- `ram_wr_data`  out  8  RAM write data.
- `ram_wr_en`  out  1  RAM write enable, one cycle per pixel.
- `img_valid`  out  1  complete frame present in RAM; level, high throughout HOLD.
- `busy`  out  1  high in LOAD or CHECK.
- `pixel_count`  out  10  pixels written in the current frame.
- `err_timeout`  out  1  sticky; set on timeout abort.
- `err_cksum`  out  1  sticky; set on checksum mismatch (0 when checksum is compiled out).

## Operation
- States: HUNT0, HUNT1, LOAD, CHECK (checksum build only), HOLD.
- HUNT0:
  - `rx_valid` && byte == `SYNC0` → HUNT1.
  - Any other byte: stay in HUNT0.
- HUNT1:
  - Byte == `SYNC1` → LOAD. On this transition, `pixel_count` ← 0, checksum accumulator ← 0, and both error flags are cleared.
  - Byte == `SYNC0` → stay in HUNT1.
  - Any other byte → HUNT0.
- LOAD, on each `rx_valid`:
  - Register `ram_wr_addr` ← `pixel_count`, `ram_wr_data` ← `rx_data`, `ram_wr_en` ← 1.
  - Increment `pixel_count` and add the byte to the accumulator (mod 256).
  - The byte that brings `pixel_count` to `N_PIXELS` ends the payload: → HOLD (no checksum) or → CHECK.
- CHECK: next `rx_valid` byte is compared with the accumulator.
  - Equal → HOLD.
  - Unequal → `err_cksum` ← 1, → HUNT0.
- HOLD:
  - `img_valid` = 1 and all `rx_valid` bytes are dropped (no writes, no counting).
  - `img_ack` → HUNT0 on the next edge, with `img_valid` falling on that same edge.
- Timeout, active in LOAD and CHECK only:
  - The idle counter clears on every `rx_valid` and on entry to LOAD.
  - When the counter reaches `TIMEOUT_CYCLES`: `err_timeout` ← 1, → HUNT0.
  - RAM contents written before the abort are left in place; `img_valid` does not rise.
- `img_ack` outside HOLD is ignored.
- Pixel address never wraps: writes occur only for addresses 0..`N_PIXELS`-1.

## Timing
- Reset values: state HUNT0; `ram_wr_addr` 0, `ram_wr_data` 0, `ram_wr_en` 0, `img_valid` 0, `busy` 0, `pixel_count` 0, `err_timeout` 0, `err_cksum` 0. The accumulator and idle counter also reset to 0.
- Write latency: a pixel strobe sampled at edge E drives `ram_wr_en`/addr/data high between E and E+1. The RAM commits the pixel at E+1.
- `ram_wr_en` is deasserted on every edge that has no accepted pixel. Back-to-back strobes on consecutive cycles give consecutive one-cycle writes.
- No checksum: `img_valid` rises at E_last+1, the edge on which the final pixel commits to the RAM, so asynchronous RAM reads are valid from that cycle on.
- Checksum build: the checksum byte sampled at edge C gives `img_valid` = 1 (or `err_cksum` = 1) from edge C.
- `busy` is a registered decode of the state: it rises on the edge entering LOAD and falls on the edge leaving LOAD/CHECK.
- `rst_n` asserted mid-frame forces all outputs to their reset values immediately, including `ram_wr_en` = 0; the partial frame is abandoned.
- Simultaneous timeout expiry and `rx_valid`: the byte wins, the counter clears and there is no abort.

## Configuration
- `IMAGE_LOADER_CHECKSUM_EN` defined:
  - CHECK state and the 8-bit additive accumulator are present.
  - The frame is header + `N_PIXELS` bytes + 1 checksum byte (sum of pixels mod 256).
- Undefined:
  - No CHECK state and no accumulator; `err_cksum` is tied to 0.
  - The frame ends after the final pixel.

## Test plan
- Reset, then stream 0xAA 0x55 followed by pixel bytes (i mod 256) for i = 0..783 on every 3rd cycle → 784 writes at addresses 0..783 with data i mod 256; `img_valid` rises on the commit edge of address 783; `pixel_count` = 784.
- Leading garbage 0x12 0xAA 0xAA 0x55 followed by a frame → header found; first write is at address 0 with the first pixel byte.
- In HOLD, send 10 extra bytes, then pulse `img_ack` → no `ram_wr_en` pulses during HOLD; `img_valid` = 0 one edge after the ack; state is HUNT0.
- After 100 pixels, stall the stream for `TIMEOUT_CYCLES` cycles → `err_timeout` = 1, `busy` = 0, `img_valid` stays 0. A new header clears `err_timeout`.
- With `IMAGE_LOADER_CHECKSUM_EN`: all 784 pixels = 0x01 and checksum 0x10 (784 mod 256) → `img_valid` = 1. Same frame with checksum 0x11 → `err_cksum` = 1, `img_valid` = 0.
- Assert `rst_n` = 0 during the pixel 400 write cycle → `ram_wr_en` drops immediately; after release all outputs are 0 and state is HUNT0.
